// File: rtl/adder_pipelined_nbit.sv
// Segmented add/subtract pipeline: one SEG_WIDTH slice per stage, carry registered
// between stages, with a valid/ready handshake and a single global stall enable.
module adder_pipelined_nbit #(
    parameter int BIT_WIDTH = 16,
    parameter int SEG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow
);

    localparam int NUM_STAGES = BIT_WIDTH / SEG_WIDTH;
    localparam int LAST       = NUM_STAGES - 1;

    generate
        if ((BIT_WIDTH % SEG_WIDTH) != 0) begin : g_width_check
            $error("BIT_WIDTH must be a multiple of SEG_WIDTH");
        end
    endgenerate

    function automatic logic [SEG_WIDTH:0] seg_add(
        input logic [SEG_WIDTH-1:0] x,
        input logic [SEG_WIDTH-1:0] y,
        input logic                 c
    );
        return {1'b0, x} + {1'b0, y} + {{SEG_WIDTH{1'b0}}, c};
    endfunction

    logic                                 en;
    logic [BIT_WIDTH-1:0]                 b_eff;
    logic                                 cin_eff;

    logic [NUM_STAGES-1:0]                valid_q, valid_d;
    logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] a_q, a_d;
    logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] b_q, b_d;
    logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] sum_q, sum_d;
    logic [NUM_STAGES-1:0]                carry_q, carry_d;
    logic                                 ovf_q, ovf_d;
    logic [SEG_WIDTH:0]                   seg;
    logic                                 unused_bits;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub ? ~carry_in : carry_in;

    // Each stage adds its own slice; operands and finished sum slices ride along unchanged.
    always_comb begin
        valid_d = '0;
        a_d     = '0;
        b_d     = '0;
        sum_d   = '0;
        carry_d = '0;
        seg     = '0;

        seg                          = seg_add(a[SEG_WIDTH-1:0], b_eff[SEG_WIDTH-1:0], cin_eff);
        valid_d[0]                   = in_valid;
        a_d[0]                       = a;
        b_d[0]                       = b_eff;
        sum_d[0][SEG_WIDTH-1:0]      = seg[SEG_WIDTH-1:0];
        carry_d[0]                   = seg[SEG_WIDTH];

        for (int k = 1; k < NUM_STAGES; k++) begin
            seg        = seg_add(a_q[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                                 b_q[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                                 carry_q[k-1]);
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            sum_d[k]   = sum_q[k-1];
            sum_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
            carry_d[k] = seg[SEG_WIDTH];
        end
    end

    // Carry into the MSB is recovered from the MSB operand and sum bits.
    assign ovf_d = a_d[LAST][BIT_WIDTH-1] ^ b_d[LAST][BIT_WIDTH-1]
                 ^ sum_d[LAST][BIT_WIDTH-1] ^ carry_d[LAST];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid   = valid_q[LAST];
    assign sum         = sum_q[LAST];
    assign carry_out   = carry_q[LAST];
    assign overflow    = ovf_q;
    assign unused_bits = ^{a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// Bench for adder_pipelined_nbit: a 4-stage instance and a single-stage instance
// share stimulus and are both scored against a plain-arithmetic reference model.
module tb_adder_pipelined_nbit;

    localparam int BW = 16;

    typedef struct {
        logic [17:0] res;
        int          acc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          carry_in;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] sum;
    logic          carry_out;
    logic          overflow;

    logic          deg_in_ready;
    logic          deg_out_valid;
    logic [BW-1:0] deg_sum;
    logic          deg_carry_out;
    logic          deg_overflow;

    exp_t        q_main[$];
    exp_t        q_deg[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    int          pops_main = 0;
    int          last_lat_main;
    int          last_lat_deg;
    logic [17:0] last_obs_main;
    logic [17:0] last_obs_deg;

    adder_pipelined_nbit #(.BIT_WIDTH(BW), .SEG_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    adder_pipelined_nbit #(.BIT_WIDTH(BW), .SEG_WIDTH(BW)) dut_deg (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(deg_in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(deg_out_valid), .out_ready(out_ready),
        .sum(deg_sum), .carry_out(deg_carry_out), .overflow(deg_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result is {sum, carry_out, overflow} from integer arithmetic on the operands.
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic c, input logic s);
        int ux, uy, sx, sy, ci, ru, rs;
        logic [15:0] r16;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ci = int'(c);
        ru = s ? (ux - uy - ci) : (ux + uy + ci);
        rs = s ? (sx - sy - ci) : (sx + sy + ci);
        r16 = ru[15:0];
        co = s ? (ru >= 0) : (ru > 65535);
        ov = (rs > 32767) || (rs < -32768);
        return {r16, co, ov};
    endfunction

    task automatic checkOutput(input bit is_deg);
        exp_t        e;
        logic [17:0] obs;
        int          depth;
        obs   = is_deg ? {deg_sum, deg_carry_out, deg_overflow} : {sum, carry_out, overflow};
        depth = is_deg ? q_deg.size() : q_main.size();
        compared++;
        assert (depth != 0) else begin
            mismatched++;
            $error("[TB] FAIL unexpected_output deg=%0d: observed result %h, expected no result", is_deg, obs);
        end
        if (depth != 0) begin
            e = is_deg ? q_deg.pop_front() : q_main.pop_front();
            compared++;
            assert (obs === e.res) else begin
                mismatched++;
                $error("[TB] FAIL result deg=%0d: observed %h, expected %h", is_deg, obs, e.res);
            end
            if (is_deg) begin
                last_lat_deg = cycle - e.acc;
                last_obs_deg = obs;
            end else begin
                last_lat_main = cycle - e.acc;
                last_obs_main = obs;
                pops_main++;
            end
        end
    endtask

    // Drive one cycle's inputs, score accepts and pops before the edge, then advance.
    task automatic applyStimulus(input logic v, input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic s, input logic ordy,
                                 input logic r, output logic acc);
        exp_t e;
        rst       = r;
        in_valid  = v;
        a         = x;
        b         = y;
        carry_in  = c;
        sub       = s;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (!r) begin
            e.res = ref_model(x, y, c, s);
            e.acc = cycle;
            acc   = (in_valid && in_ready === 1'b1);
            if (acc) q_main.push_back(e);
            if (in_valid && deg_in_ready === 1'b1) q_deg.push_back(e);
            if (out_valid === 1'b1 && out_ready) checkOutput(1'b0);
            if (deg_out_valid === 1'b1 && out_ready) checkOutput(1'b1);
        end
        @(posedge clk);
        cycle++;
        if (r) begin
            q_main.delete();
            q_deg.delete();
        end
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int i = 0; i < 12 && (q_main.size() != 0 || q_deg.size() != 0); i++)
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        check({tag, "_drained"}, 32'(q_main.size() + q_deg.size()), 32'd0);
    endtask

    // One isolated op on an idle pipeline: value and latency on both instances.
    task automatic runSingle(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic c, input logic s, input logic [17:0] expv);
        logic acc;
        last_lat_main = -1;
        last_lat_deg  = -1;
        applyStimulus(1'b1, x, y, c, s, 1'b1, 1'b0, acc);
        check({tag, "_accept"}, 32'(acc), 32'd1);
        drain(tag);
        check({tag, "_latency4"}, 32'(last_lat_main), 32'd4);
        check({tag, "_latency1"}, 32'(last_lat_deg), 32'd1);
        check({tag, "_value"}, 32'(last_obs_main), 32'(expv));
        check({tag, "_value_deg"}, 32'(last_obs_deg), 32'(expv));
    endtask

    logic [15:0] opa[8];
    logic [15:0] opb[8];
    logic        opc[8];
    logic        ops[8];
    logic [17:0] snap;
    logic        acc;
    int          sent;
    int          stall;
    int          stalled_done;
    int          pops_before;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        $display("[TB] reset with inputs presented");
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, acc);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        check("post_rst_idle", 32'(out_valid), 32'd0);

        $display("[TB] directed arithmetic");
        runSingle("full_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
        runSingle("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
        runSingle("add_cin", 16'h1234, 16'h1111, 1'b1, 1'b0, {16'h2346, 1'b0, 1'b0});
        runSingle("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
        runSingle("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});

        $display("[TB] back-pressure stream");
        for (int i = 0; i < 8; i++) begin
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
            opc[i] = 1'($urandom);
            ops[i] = 1'($urandom);
        end
        sent = 0; stall = 0; stalled_done = 0; pops_before = pops_main;
        for (int t = 0; t < 80; t++) begin
            if (sent == 8 && q_main.size() == 0 && stalled_done != 0) break;
            if (stalled_done == 0 && stall == 0 && out_valid === 1'b1) begin
                stall = 3;
                snap  = {sum, carry_out, overflow};
            end
            applyStimulus(sent < 8, opa[sent % 8], opb[sent % 8], opc[sent % 8], ops[sent % 8],
                          stall == 0, 1'b0, acc);
            if (acc) sent++;
            if (stall > 0) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_frozen", 32'({sum, carry_out, overflow}), 32'(snap));
                stall--;
                if (stall == 0) stalled_done = 1;
            end
        end
        check("stream_sent", 32'(sent), 32'd8);
        check("stream_stalled", 32'(stalled_done), 32'd1);
        check("stream_count", 32'(pops_main - pops_before), 32'd8);
        drain("stream");

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, acc);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_valid_deg", 32'(deg_out_valid), 32'd0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        opa[0] = 16'($urandom);
        opb[0] = 16'($urandom);
        opc[0] = 1'($urandom);
        ops[0] = 1'($urandom);
        runSingle("after_rst", opa[0], opb[0], opc[0], ops[0], ref_model(opa[0], opb[0], opc[0], ops[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adder_pipelined_nbit.md
Name: adder_pipelined_nbit

Overview:
Parametrised, pipelined successor to the team's ripple-carry n-bit adder. The BIT_WIDTH add/subtract is split into SEG_WIDTH-bit segments, one segment per pipeline stage, with the carry registered between stages, so wide operands close timing at full throughput. A valid/ready handshake on input and output lets it sit between streaming datapath blocks. It also reports a correct unsigned carry/borrow and signed overflow.

Parameters:
BIT_WIDTH, 16, operand and result width; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 4, bits added per stage. NUM_STAGES = BIT_WIDTH/SEG_WIDTH is a derived localparam. Elaboration fails if BIT_WIDTH % SEG_WIDTH != 0.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  a, b, carry_in and sub are valid this cycle
in_ready  out  1  block accepts the input this cycle
a  in  BIT_WIDTH  operand A
b  in  BIT_WIDTH  operand B
carry_in  in  1  carry-in for add; borrow-in for subtract
sub  in  1  0 = add, 1 = subtract
out_valid  out  1  sum, carry_out and overflow are valid
out_ready  in  1  downstream accepts the result
sum  out  BIT_WIDTH  result
carry_out  out  1  carry out of the MSB (for subtract, 1 = no borrow)
overflow  out  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Arithmetic:
  - Add: {carry_out, sum} = a + b + carry_in.
  - Subtract: b_eff = ~b and cin_eff = ~carry_in, so the result is a - b - carry_in mod 2^BIT_WIDTH.
- Overflow: overflow = (carry into the MSB) XOR (carry out of the MSB). This is the true signed-overflow rule.
- Stage k (0 = least significant) adds segment k of a and b_eff using the carry registered from stage k-1. Stage 0 uses cin_eff.
- Unprocessed upper operand segments and completed lower sum segments travel with the data through delay registers. All result bits leave together and aligned.
- Each stage holds a valid bit.
- Pipeline advance uses a global enable: en = out_ready | ~out_valid.
  - in_ready = en.
  - Input is accepted when in_valid & in_ready.
  - When en=1, every stage shifts forward. A bubble (valid=0) enters stage 0 when in_valid=0.
  - When en=0, all stage registers hold, and sum, carry_out and overflow stay stable while out_valid=1.
- Latency: exactly NUM_STAGES cycles from the accept edge to out_valid=1, with no stalls. Throughput is 1 result per cycle. Bubbles are not collapsed.
- Ordering: results come out in acceptance order. No operation is dropped or duplicated under any out_ready pattern.
- Reset:
  - All valid bits clear. out_valid=0, sum=0, carry_out=0, overflow=0.
  - in_ready=1 while rst is high, because out_valid=0. Inputs presented while rst is high are discarded.
  - In-flight operations are discarded if rst is asserted mid-operation.
- Edge cases:
  - SEG_WIDTH = BIT_WIDTH degenerates to a single registered stage with latency 1.
  - in_valid, a, b, carry_in and sub are ignored when not accepted.
  - Simultaneous output pop and input push in the same cycle is legal and required at full rate.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, carry_out=0, overflow=0, in_ready=1. No output ever appears for the inputs presented during reset.
2. Full-carry ripple across all segments (BIT_WIDTH=16, SEG_WIDTH=4): a=0xFFFF, b=0x0001, carry_in=0, sub=0, out_ready=1 -> exactly 4 cycles later sum=0x0000, carry_out=1, overflow=0.
3. Signed overflow on add: a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1. Then a=0x1234, b=0x1111, carry_in=1 -> sum=0x2346, carry_out=0, overflow=0.
4. Subtract: a=0x0005, b=0x0007, carry_in=0 -> sum=0xFFFE, carry_out=0, overflow=0. Then a=0x8000, b=0x0001, carry_in=0 -> sum=0x7FFF, carry_out=1, overflow=1.
5. Back-pressure: stream 8 random ops back-to-back, and drop out_ready for 3 cycles after the first result appears -> in_ready=0 and outputs frozen during the stall. All 8 results match the reference model, in order, with none lost or duplicated.
6. Reset mid-flight and degenerate config:
   - Assert rst for 1 cycle while 3 ops are in flight -> those ops never appear, and the next accepted op emerges after 4 cycles.
   - Rerun scenario 2 with SEG_WIDTH=16 -> latency 1, same values.
